// File: rtl/alu_pkg.sv
// Shared types and field positions for the ALU operand-fetch stage.
package alu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned RAW   = $clog2(NREGS);

    localparam int unsigned FUNCT_LSB = 28;
    localparam int unsigned IMMSEL_BIT = 27;
    localparam int unsigned RD_LSB    = 22;
    localparam int unsigned RS_LSB    = 17;
    localparam int unsigned RT_LSB    = 12;
    localparam int unsigned SHAMT_LSB = 7;
    localparam int unsigned IMM_LSB   = 0;

    typedef logic [3:0]     funct_t;
    typedef logic [RAW-1:0] reg_addr_t;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      shamt;
        funct_t          funct;
        reg_addr_t       rd;
    } bundle_t;

    typedef enum logic {StEmpty, StFull} out_state_e;

    function automatic logic [XLEN-1:0] sext_imm(input logic [15:0] imm);
        return {{(XLEN-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/alu_operand_fetch_if.sv
// Instruction-in, operand-bundle-out and writeback signals of the operand-fetch stage.
interface alu_operand_fetch_if;
    import alu_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      shamt;
    funct_t          funct;
    reg_addr_t       rd;
    logic            wb_en;
    reg_addr_t       wb_addr;
    logic [XLEN-1:0] wb_data;

    modport master (
        output in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, a, b, shamt, funct, rd
    );

    modport slave (
        input  in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, a, b, shamt, funct, rd
    );

endinterface

// File: rtl/regfile_2r1w.sv
// Two-read one-write register file with write-to-read bypass; r0 is hardwired to zero.
module regfile_2r1w
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  reg_addr_t       raddr_a,
    input  reg_addr_t       raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b,
    input  logic            we,
    input  reg_addr_t       waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = mem[raddr_a];
        if (raddr_a == '0)                rdata_a = '0;
        else if (we && waddr == raddr_a)  rdata_a = wdata;
    end

    always_comb begin
        rdata_b = mem[raddr_b];
        if (raddr_b == '0)                rdata_b = '0;
        else if (we && waddr == raddr_b)  rdata_b = wdata;
    end

endmodule

// File: rtl/alu_operand_fetch.sv
// Operand fetch ahead of the ALU: regfile read, busy-bit RAW interlock and a registered
// valid/ready output stage.
module alu_operand_fetch
    import alu_pkg::*;
(
    input logic                clk,
    input logic                rst_n,
    alu_operand_fetch_if.slave bus
);

    reg_addr_t       rs, rt, rd_f;
    logic            imm_sel;
    logic [XLEN-1:0] rs_val, rt_val;
    logic [NREGS-1:0] busy_q, busy_d;
    out_state_e      state_q, state_d;
    bundle_t         out_q, out_d;
    logic            rs_blocked, rt_blocked, hazard, accept;

    assign rs      = bus.instr[RS_LSB +: RAW];
    assign rt      = bus.instr[RT_LSB +: RAW];
    assign rd_f    = bus.instr[RD_LSB +: RAW];
    assign imm_sel = bus.instr[IMMSEL_BIT];

    regfile_2r1w u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rs_val),
        .rdata_b (rt_val),
        .we      (bus.wb_en),
        .waddr   (bus.wb_addr),
        .wdata   (bus.wb_data)
    );

    // A source being written back this cycle is served by the bypass, so it never blocks.
    assign rs_blocked = busy_q[rs] && !(bus.wb_en && bus.wb_addr == rs);
    assign rt_blocked = !imm_sel && busy_q[rt] && !(bus.wb_en && bus.wb_addr == rt);
    assign hazard     = rs_blocked || rt_blocked;

    assign bus.in_ready = rst_n && (state_q == StEmpty || bus.out_ready) && !hazard;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        busy_d = busy_q;
        if (bus.wb_en) busy_d[bus.wb_addr] = 1'b0;
        if (accept && rd_f != '0) busy_d[rd_f] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        out_d = out_q;
        if (accept) begin
            out_d.a     = rs_val;
            out_d.b     = imm_sel ? sext_imm(bus.instr[IMM_LSB +: 16]) : rt_val;
            out_d.shamt = bus.instr[SHAMT_LSB +: 5];
            out_d.funct = bus.instr[FUNCT_LSB +: 4];
            out_d.rd    = rd_f;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (!accept && bus.out_ready) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            busy_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            out_q   <= out_d;
        end
    end

    assign bus.out_valid = (state_q == StFull);
    assign bus.a         = out_q.a;
    assign bus.b         = out_q.b;
    assign bus.shamt     = out_q.shamt;
    assign bus.funct     = out_q.funct;
    assign bus.rd        = out_q.rd;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Randomized and directed bench for alu_operand_fetch against a behavioural register/busy model.
module tb_alu_operand_fetch;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_pass = 0;

    alu_operand_fetch_if ifc ();

    alu_operand_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: architectural registers, busy flags and the pending bundle.
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_valid;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_shamt, m_rd;
    logic [3:0]  m_funct;

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (ifc.wb_en && ifc.wb_addr == r) return ifc.wb_data;
        return m_regs[r];
    endfunction

    function automatic bit m_blocked(input logic [4:0] r);
        return r != 5'd0 && m_busy[r] && !(ifc.wb_en && ifc.wb_addr == r);
    endfunction

    always @(negedge clk) begin
        logic [4:0]  rs, rt, rd;
        logic        isel, exp_ready, acc;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_busy[i] = 1'b0;
            end
            m_valid = 1'b0; m_a = '0; m_b = '0; m_shamt = '0; m_funct = '0; m_rd = '0;
            chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
            chk("rst_a", ifc.a, 32'd0);
            chk("rst_b", ifc.b, 32'd0);
            chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd0);
        end else begin
            chk("out_valid", {31'd0, ifc.out_valid}, {31'd0, m_valid});
            chk("a", ifc.a, m_a);
            chk("b", ifc.b, m_b);
            chk("shamt", {27'd0, ifc.shamt}, {27'd0, m_shamt});
            chk("funct", {28'd0, ifc.funct}, {28'd0, m_funct});
            chk("rd", {27'd0, ifc.rd}, {27'd0, m_rd});
            rs   = ifc.instr[21:17];
            rt   = ifc.instr[16:12];
            rd   = ifc.instr[26:22];
            isel = ifc.instr[27];
            exp_ready = !(m_valid && !ifc.out_ready) && !m_blocked(rs) && !(!isel && m_blocked(rt));
            chk("in_ready", {31'd0, ifc.in_ready}, {31'd0, exp_ready});
            acc = ifc.in_valid && exp_ready;
            if (acc) begin
                m_valid = 1'b1;
                m_a     = m_read(rs);
                m_b     = isel ? {{16{ifc.instr[15]}}, ifc.instr[15:0]} : m_read(rt);
                m_shamt = ifc.instr[11:7];
                m_funct = ifc.instr[31:28];
                m_rd    = rd;
            end else if (ifc.out_ready) begin
                m_valid = 1'b0;
            end
            if (ifc.wb_en && ifc.wb_addr != 5'd0) m_regs[ifc.wb_addr] = ifc.wb_data;
            if (ifc.wb_en) m_busy[ifc.wb_addr] = 1'b0;
            if (acc && rd != 5'd0) m_busy[rd] = 1'b1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_r(input logic [3:0] f, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] sh);
        return {f, 1'b0, rd, rs, rt, sh, 7'd0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [3:0] f, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic b16,
                                         input logic [15:0] imm);
        return {f, 1'b1, rd, rs, b16, imm};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        rst_n         = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.instr     = '0;
        ifc.out_ready = 1'b1;
        ifc.wb_en     = 1'b0;
        ifc.wb_addr   = '0;
        ifc.wb_data   = '0;
        #1 rst_n = 1'b0;
        repeat (2) tick;
        rst_n = 1'b1;

        // Random traffic over r0..r7 to provoke hazards, bypasses and backpressure.
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            w[26:25] = 2'b0;
            w[21:20] = 2'b0;
            if (!w[27]) w[16:15] = 2'b0;
            ifc.instr     = w;
            ifc.in_valid  = ($urandom % 4) != 0;
            ifc.out_ready = ($urandom % 4) != 0;
            ifc.wb_en     = $urandom % 2;
            ifc.wb_addr   = 5'($urandom % 8);
            ifc.wb_data   = $urandom;
            tick;
        end

        // Mid-stream reset.
        rst_n = 1'b0;
        #1;
        chk("lit_rst_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("lit_rst_a", ifc.a, 32'd0);
        chk("lit_rst_funct", {28'd0, ifc.funct}, 32'd0);
        chk("lit_rst_rd", {27'd0, ifc.rd}, 32'd0);
        tick;
        ifc.in_valid = 1'b0; ifc.wb_en = 1'b0; ifc.out_ready = 1'b1;
        rst_n = 1'b1;
        tick;

        ifc.wb_en = 1'b1; ifc.wb_addr = 5'd3; ifc.wb_data = 32'h0000_0011;
        tick;
        ifc.wb_en = 1'b0;

        ifc.in_valid = 1'b1;
        ifc.instr    = mk_r(4'h2, 5'd0, 5'd3, 5'd0, 5'd5);
        #1 chk("lit_fetch_ready", {31'd0, ifc.in_ready}, 32'd1);
        tick;
        chk("lit_fetch_a", ifc.a, 32'h11);
        chk("lit_fetch_b", ifc.b, 32'h0);
        chk("lit_fetch_shamt", {27'd0, ifc.shamt}, 32'd5);
        chk("lit_fetch_funct", {28'd0, ifc.funct}, 32'd2);
        chk("lit_fetch_valid", {31'd0, ifc.out_valid}, 32'd1);

        ifc.instr = mk_i(4'h1, 5'd0, 5'd0, 1'b1, 16'hFFF0);
        tick;
        chk("lit_imm_b", ifc.b, 32'hFFFF_FFF0);

        ifc.instr = mk_r(4'h0, 5'd4, 5'd0, 5'd0, 5'd0);
        tick;
        ifc.instr = mk_r(4'h3, 5'd0, 5'd4, 5'd0, 5'd0);
        #1 chk("lit_raw_stall0", {31'd0, ifc.in_ready}, 32'd0);
        repeat (2) begin
            tick;
            chk("lit_raw_stall", {31'd0, ifc.in_ready}, 32'd0);
        end
        ifc.wb_en = 1'b1; ifc.wb_addr = 5'd4; ifc.wb_data = 32'hAB;
        #1 chk("lit_raw_release", {31'd0, ifc.in_ready}, 32'd1);
        tick;
        ifc.wb_en = 1'b0;
        chk("lit_raw_a", ifc.a, 32'hAB);
        chk("lit_raw_funct", {28'd0, ifc.funct}, 32'd3);

        ifc.instr = mk_r(4'h5, 5'd0, 5'd3, 5'd4, 5'd7);
        tick;
        ifc.out_ready = 1'b0;
        ifc.instr     = mk_r(4'h6, 5'd0, 5'd4, 5'd3, 5'd1);
        repeat (3) begin
            #1;
            chk("lit_bp_ready", {31'd0, ifc.in_ready}, 32'd0);
            chk("lit_bp_valid", {31'd0, ifc.out_valid}, 32'd1);
            chk("lit_bp_a", ifc.a, 32'h11);
            chk("lit_bp_b", ifc.b, 32'hAB);
            chk("lit_bp_funct", {28'd0, ifc.funct}, 32'd5);
            tick;
        end
        ifc.out_ready = 1'b1;
        #1 chk("lit_bp_release", {31'd0, ifc.in_ready}, 32'd1);
        tick;
        chk("lit_bp_next_a", ifc.a, 32'hAB);
        chk("lit_bp_next_funct", {28'd0, ifc.funct}, 32'd6);
        ifc.instr = mk_r(4'h7, 5'd0, 5'd0, 5'd3, 5'd2);
        tick;
        chk("lit_bp_third_funct", {28'd0, ifc.funct}, 32'd7);
        chk("lit_bp_third_b", ifc.b, 32'h11);
        ifc.in_valid = 1'b0;
        tick;
        chk("lit_drain_valid", {31'd0, ifc.out_valid}, 32'd0);

        ifc.wb_en = 1'b1; ifc.wb_addr = 5'd0; ifc.wb_data = 32'hFFFF_FFFF;
        tick;
        ifc.wb_en = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.instr    = mk_r(4'h8, 5'd0, 5'd0, 5'd0, 5'd0);
        tick;
        chk("lit_r0_a", ifc.a, 32'd0);
        ifc.instr = mk_r(4'h9, 5'd0, 5'd0, 5'd0, 5'd0);
        #1 chk("lit_r0_nostall", {31'd0, ifc.in_ready}, 32'd1);
        tick;
        ifc.in_valid = 1'b0;
        repeat (3) tick;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
